// File: rtl/sys_pkg.sv
// Shared definitions for the system-call responder: action codes, FSM states
// and a small decode helper.
// Optional feature macro: SYS_CYCLE_CNT_EN (adds PRINTCYC and moves HALT to 111).
package sys_pkg;

    localparam logic [2:0] SYS_PRINT    = 3'b000;
    localparam logic [2:0] SYS_PRINT2   = 3'b001;
    localparam logic [2:0] SYS_DELAY    = 3'b010;
    localparam logic [2:0] SYS_PRINTCYC = 3'b011;
`ifdef SYS_CYCLE_CNT_EN
    localparam logic [2:0] SYS_HALT     = 3'b111;
`else
    localparam logic [2:0] SYS_HALT     = 3'b011;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND0,
        ST_SEND1,
        ST_DELAY,
        ST_HALT,
        ST_DONE
    } sys_state_t;

    // True for actions that push two words to the host.
    function automatic logic sends_two(input logic [2:0] funct3);
`ifdef SYS_CYCLE_CNT_EN
        return (funct3 == SYS_PRINT2) || (funct3 == SYS_PRINTCYC);
`else
        return (funct3 == SYS_PRINT2);
`endif
    endfunction

endpackage

// File: rtl/sys_if.sv
// Request/completion bus between EX and the sys unit, plus the host
// valid/ready channel. The sys unit is the slave; EX and the host form the master side.
interface sys_if #(
    parameter int DW = 32
);

    logic          EX__sys_en;
    logic [2:0]    EX__sys_funct3;
    logic [DW-1:0] EX__sys_rs_data;
    logic [DW-1:0] EX__sys_rt_data;
    logic          sys__EX_done;
    logic          sys__host_valid;
    logic          host__sys_ready;
    logic [2:0]    sys__host_code;
    logic [DW-1:0] sys__host_data;

    modport slave (
        input  EX__sys_en,
        input  EX__sys_funct3,
        input  EX__sys_rs_data,
        input  EX__sys_rt_data,
        input  host__sys_ready,
        output sys__EX_done,
        output sys__host_valid,
        output sys__host_code,
        output sys__host_data
    );

    modport master (
        output EX__sys_en,
        output EX__sys_funct3,
        output EX__sys_rs_data,
        output EX__sys_rt_data,
        output host__sys_ready,
        input  sys__EX_done,
        input  sys__host_valid,
        input  sys__host_code,
        input  sys__host_data
    );

endinterface

// File: rtl/sys_down_counter.sv
// Down-counter used by the DELAY action. Loaded with the requested cycle
// count, decremented while the FSM waits, and flags the last waiting cycle.
module sys_down_counter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          is_one_o
);

    logic [DW-1:0] count_q;
    logic [DW-1:0] count_d;

    // Load has priority; decrement saturates at zero so it can never wrap.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - {{(DW-1){1'b0}}, 1'b1};
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_one_o = (count_q == {{(DW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/sys_unit.sv
// System-call responder: accepts a sys request from EX, performs print,
// delay or halt, and pulses done for one cycle to release the EX stall.
// Optional feature macro: SYS_CYCLE_CNT_EN (64-bit cycle counter, PRINTCYC).
module sys_unit
    import sys_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    sys_if.slave        bus,
    output logic        sys_halted,
    output logic        sys_busy
`ifdef SYS_CYCLE_CNT_EN
    ,
    output logic [63:0] sys_cycle_count
`endif
);

    sys_state_t    state_q, state_d;
    logic [2:0]    funct3_q;
    logic [DW-1:0] arg1_q;
    logic          accept;
    logic          cntIsOne;
    logic [DW-1:0] capArg0, capArg1;
    logic          done_q, valid_q, halted_q, busy_q;
    logic [2:0]    code_q, code_d;
    logic [DW-1:0] data_q, data_d;

    assign accept = (state_q == ST_IDLE) && bus.EX__sys_en;

`ifdef SYS_CYCLE_CNT_EN
    logic [63:0] cycCnt_q;

    // Free-running cycle counter, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycCnt_q <= '0;
        end else begin
            cycCnt_q <= cycCnt_q + 64'd1;
        end
    end

    assign sys_cycle_count = cycCnt_q;

    // PRINTCYC replaces the operands with the two halves of the cycle count.
    always_comb begin
        capArg0 = bus.EX__sys_rs_data;
        capArg1 = bus.EX__sys_rt_data;
        if (bus.EX__sys_funct3 == SYS_PRINTCYC) begin
            capArg0 = DW'(cycCnt_q[31:0]);
            capArg1 = DW'(cycCnt_q[63:32]);
        end
    end
`else
    assign capArg0 = bus.EX__sys_rs_data;
    assign capArg1 = bus.EX__sys_rt_data;
`endif

    sys_down_counter #(
        .DW(DW)
    ) u_down_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (accept && (bus.EX__sys_funct3 == SYS_DELAY)),
        .load_val_i(bus.EX__sys_rs_data),
        .dec_i     (state_q == ST_DELAY),
        .is_one_o  (cntIsOne)
    );

    // Next-state decode for the action FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.EX__sys_en) begin
                    case (bus.EX__sys_funct3)
                        SYS_PRINT,
                        SYS_PRINT2:   state_d = ST_SEND0;
                        SYS_DELAY:    state_d = (bus.EX__sys_rs_data != '0) ? ST_DELAY : ST_DONE;
`ifdef SYS_CYCLE_CNT_EN
                        SYS_PRINTCYC: state_d = ST_SEND0;
`endif
                        SYS_HALT:     state_d = ST_HALT;
                        default:      state_d = ST_DONE;
                    endcase
                end
            end
            ST_SEND0: begin
                if (bus.host__sys_ready) begin
                    state_d = sends_two(funct3_q) ? ST_SEND1 : ST_DONE;
                end
            end
            ST_SEND1: begin
                if (bus.host__sys_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DELAY: begin
                if (cntIsOne) begin
                    state_d = ST_DONE;
                end
            end
            ST_HALT: state_d = ST_HALT;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Host code/data change only when a new word is about to be presented, so they stay stable while valid is high.
    always_comb begin
        code_d = code_q;
        data_d = data_q;
        if (accept && (state_d == ST_SEND0)) begin
            code_d = bus.EX__sys_funct3;
            data_d = capArg0;
        end else if ((state_q == ST_SEND0) && (state_d == ST_SEND1)) begin
            data_d = arg1_q;
        end
    end

    // State, captured request and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            funct3_q <= '0;
            arg1_q   <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
            code_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            if (accept) begin
                funct3_q <= bus.EX__sys_funct3;
                arg1_q   <= capArg1;
            end
            done_q   <= (state_d == ST_DONE);
            valid_q  <= (state_d == ST_SEND0) || (state_d == ST_SEND1);
            halted_q <= (state_d == ST_HALT);
            busy_q   <= (state_d != ST_IDLE);
            code_q   <= code_d;
            data_q   <= data_d;
        end
    end

    assign bus.sys__EX_done    = done_q;
    assign bus.sys__host_valid = valid_q;
    assign bus.sys__host_code  = code_q;
    assign bus.sys__host_data  = data_q;
    assign sys_halted          = halted_q;
    assign sys_busy            = busy_q;

endmodule

// File: tb/tb_sys_unit.sv
// Testbench for sys_unit: directed cases for each action plus randomized
// requests and host back-pressure, checked against a transaction-level model.
// Optional feature macro: SYS_CYCLE_CNT_EN (adds PRINTCYC checks).
module tb_sys_unit;

    localparam int DW = 32;
`ifdef SYS_CYCLE_CNT_EN
    localparam logic [2:0] HALT_CODE = 3'b111;
`else
    localparam logic [2:0] HALT_CODE = 3'b011;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic halted;
    logic busy;
`ifdef SYS_CYCLE_CNT_EN
    logic [63:0] cycCount;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    longint unsigned tbCycle;

    sys_if #(.DW(DW)) bus ();

    sys_unit #(
        .DW(DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sys_halted(halted),
        .sys_busy  (busy)
`ifdef SYS_CYCLE_CNT_EN
        ,
        .sys_cycle_count(cycCount)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Reference count of cycles since reset release.
    always @(posedge clk) begin
        if (!rst_n) tbCycle <= 0;
        else        tbCycle <= tbCycle + 1;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Host ready pattern: 0 random, 1 always high, 2 low for three cycles then high.
    function automatic logic pickReady(input int mode, input int cyc);
        case (mode)
            1:       return 1'b1;
            2:       return (cyc >= 4);
            default: return 1'b1 & $urandom_range(0, 1);
        endcase
    endfunction

    // Issue one request (called at a negedge) and follow it to its done pulse.
    task automatic applyStimulus(input logic [2:0] f3, input logic [DW-1:0] a0,
                                 input logic [DW-1:0] a1, input int readyMode);
        logic [DW-1:0] expQ[$];
        int  expDone;
        bit  finished;
        logic rdy;
        expQ     = {};
        expDone  = -1;
        finished = 0;
        if (f3 == 3'b000) begin
            expQ.push_back(a0);
        end else if (f3 == 3'b001) begin
            expQ.push_back(a0);
            expQ.push_back(a1);
        end else if (f3 == 3'b010) begin
            expDone = (a0 == 0) ? 1 : int'(a0) + 1;
`ifdef SYS_CYCLE_CNT_EN
        end else if (f3 == 3'b011) begin
            expQ.push_back(tbCycle[31:0]);
            expQ.push_back(tbCycle[63:32]);
`endif
        end else begin
            expDone = 1;
        end

        bus.EX__sys_en      = 1'b1;
        bus.EX__sys_funct3  = f3;
        bus.EX__sys_rs_data = a0;
        bus.EX__sys_rt_data = a1;
        bus.host__sys_ready = pickReady(readyMode, 0);

        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            checkOutput("valid", bus.sys__host_valid, expQ.size() != 0);
            if (expQ.size() != 0) begin
                checkOutput("data", bus.sys__host_data, expQ[0]);
                checkOutput("code", bus.sys__host_code, f3);
            end
            checkOutput("done", bus.sys__EX_done, c == expDone);
            checkOutput("busy", busy, 1);
            if (c == expDone) begin
                finished = 1;
                break;
            end
            rdy = pickReady(readyMode, c);
            bus.host__sys_ready = rdy;
            if (expQ.size() != 0 && rdy) begin
                void'(expQ.pop_front());
                if (expQ.size() == 0) expDone = c + 1;
            end
        end
        if (!finished) checkOutput("timeout", 1, 0);

        bus.EX__sys_en      = 1'b0;
        bus.host__sys_ready = 1'b0;
        @(negedge clk);
        checkOutput("done_single", bus.sys__EX_done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_valid", bus.sys__host_valid, 0);
    endtask

    initial begin
        logic [2:0]    f3;
        logic [DW-1:0] a0;

        rst_n               = 1'b0;
        bus.EX__sys_en      = 1'b0;
        bus.EX__sys_funct3  = 3'b000;
        bus.EX__sys_rs_data = '0;
        bus.EX__sys_rt_data = '0;
        bus.host__sys_ready = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_done", bus.sys__EX_done, 0);
        checkOutput("rst_valid", bus.sys__host_valid, 0);
        checkOutput("rst_code", bus.sys__host_code, 0);
        checkOutput("rst_data", bus.sys__host_data, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_busy", busy, 0);
`ifdef SYS_CYCLE_CNT_EN
        checkOutput("rst_cyccnt", cycCount, 0);
`endif
        rst_n = 1'b1;

        applyStimulus(3'b100, 32'h0, 32'h0, 0);
        applyStimulus(3'b000, 32'hDEADBEEF, 32'h0, 2);
        applyStimulus(3'b001, 32'd1, 32'd2, 1);
        applyStimulus(3'b010, 32'd5, 32'h0, 1);
        applyStimulus(3'b010, 32'd0, 32'h0, 1);
        applyStimulus(3'b110, 32'h1234, 32'h5678, 1);
`ifdef SYS_CYCLE_CNT_EN
        checkOutput("cyccnt", cycCount, tbCycle);
        applyStimulus(3'b011, 32'h0, 32'h0, 1);
`endif

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            if (f3 == HALT_CODE) f3 = 3'b100;
            a0 = (f3 == 3'b010) ? DW'($urandom_range(0, 6)) : DW'($urandom);
            applyStimulus(f3, a0, DW'($urandom), 0);
        end

        // Reset while a transfer is pending with valid high.
        bus.EX__sys_en      = 1'b1;
        bus.EX__sys_funct3  = 3'b000;
        bus.EX__sys_rs_data = DW'($urandom);
        bus.host__sys_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midop_valid", bus.sys__host_valid, 1);
        rst_n          = 1'b0;
        bus.EX__sys_en = 1'b0;
        @(negedge clk);
        checkOutput("midop_rst_valid", bus.sys__host_valid, 0);
        checkOutput("midop_rst_done", bus.sys__EX_done, 0);
        checkOutput("midop_rst_busy", busy, 0);
        rst_n = 1'b1;
        applyStimulus(3'b001, 32'hA5A5A5A5, 32'h5A5A5A5A, 0);

        // Halt is terminal until reset and never releases EX.
        bus.EX__sys_en     = 1'b1;
        bus.EX__sys_funct3 = HALT_CODE;
        bus.host__sys_ready = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            checkOutput("halt_sticky", halted, 1);
            checkOutput("halt_no_done", bus.sys__EX_done, 0);
            checkOutput("halt_no_valid", bus.sys__host_valid, 0);
        end
        rst_n          = 1'b0;
        bus.EX__sys_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("halt_cleared", halted, 0);
        checkOutput("halt_rst_busy", busy, 0);
        applyStimulus(3'b100, 32'h0, 32'h0, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
